// File: rtl/divider_arbiter.sv
// Round-robin front end that time-shares one pipelined divider among NUM_REQ
// requesters and steers each result back to its requester via a tag line.

module divider_arbiter_lane #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int LANE    = 0
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [TAG_W-1:0]   rr_ptr,
  input  logic               rsp_fire,
  input  logic [TAG_W-1:0]   rsp_id,
  output logic               grant,
  output logic               rsp_hit
);
  logic blocked;

  // Blocked if any valid requester sits between rr_ptr and this lane in wrap order.
  always_comb begin
    int d;
    int j;
    blocked = 1'b0;
    d = LANE - int'(rr_ptr);
    if (d < 0) d = d + NUM_REQ;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if ((k < d) && req_valid[j]) blocked = 1'b1;
    end
  end

  assign grant   = req_valid[LANE] & ~blocked;
  assign rsp_hit = rsp_fire & (rsp_id == TAG_W'(LANE));
endmodule

module divider_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DIVIDEND_WIDTH = 8,
  parameter int DIVIDER_WIDTH  = 8,
  parameter int DIV_LATENCY    = 8
) (
  input  logic                                  in_clk,
  input  logic                                  reset,
  input  logic [NUM_REQ-1:0]                    in_req_valid,
  output logic [NUM_REQ-1:0]                    out_req_ready,
  input  logic [NUM_REQ*DIVIDEND_WIDTH-1:0]     in_req_dividend,
  input  logic [NUM_REQ*DIVIDER_WIDTH-1:0]      in_req_divider,
  output logic                                  out_div_valid,
  output logic [DIVIDEND_WIDTH-1:0]             out_div_dividend,
  output logic [DIVIDER_WIDTH-1:0]              out_div_divider,
  input  logic                                  in_div_valid,
  input  logic [DIVIDEND_WIDTH-1:0]             in_div_quotient,
  input  logic [DIVIDER_WIDTH-1:0]              in_div_remainder,
  output logic [NUM_REQ-1:0]                    out_rsp_valid,
  output logic [DIVIDEND_WIDTH-1:0]             out_rsp_quotient,
  output logic [DIVIDER_WIDTH-1:0]              out_rsp_remainder,
  output logic                                  out_rsp_dbz,
  output logic [$clog2(DIV_LATENCY+2):0]        out_inflight,
  output logic                                  out_sync_error
);
  localparam int TAG_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(DIV_LATENCY+2) + 1;
  localparam int STAGES = DIV_LATENCY;

  typedef struct packed {
    logic             dbz;
    logic [TAG_W-1:0] id;
  } tag_t;

  logic [NUM_REQ-1:0][DIVIDEND_WIDTH-1:0] req_dvd;
  logic [NUM_REQ-1:0][DIVIDER_WIDTH-1:0]  req_dvs;
  logic [NUM_REQ-1:0] grant, rsp_hit;
  logic [TAG_W-1:0]   rr_ptr, gnt_id;
  logic               accept;
  logic [DIVIDEND_WIDTH-1:0] sel_dvd;
  logic [DIVIDER_WIDTH-1:0]  sel_dvs;
  logic               sel_zero;

  // vld_pipe[0]/tag_pipe[0] is the issue stage; [STAGES] lines up with in_div_valid.
  logic [STAGES:0] vld_pipe;
  tag_t            tag_pipe [STAGES:0];
  logic            head_vld, rsp_fire, drop_q, rsp_dec;
  tag_t            head_tag;

  assign req_dvd = in_req_dividend;
  assign req_dvs = in_req_divider;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    divider_arbiter_lane #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .LANE(i)) u_lane (
      .req_valid (in_req_valid),
      .rr_ptr    (rr_ptr),
      .rsp_fire  (rsp_fire),
      .rsp_id    (head_tag.id),
      .grant     (grant[i]),
      .rsp_hit   (rsp_hit[i])
    );
  end

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (grant[i]) gnt_id = TAG_W'(i);
  end

  assign accept        = |grant;
  assign out_req_ready = grant;
  assign sel_dvd       = req_dvd[gnt_id];
  assign sel_dvs       = req_dvs[gnt_id];
  assign sel_zero      = (sel_dvs == '0);

  always_ff @(posedge in_clk) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (gnt_id == TAG_W'(NUM_REQ-1)) ? '0 : gnt_id + TAG_W'(1);
    end
  end

  // Issue stage; a zero divisor never reaches the divider.
  always_ff @(posedge in_clk) begin
    if (reset) begin
      out_div_dividend <= '0;
      out_div_divider  <= '0;
    end else if (accept) begin
      out_div_dividend <= sel_dvd;
      out_div_divider  <= sel_zero ? DIVIDER_WIDTH'(1) : sel_dvs;
    end
  end

  always_ff @(posedge in_clk) begin
    if (reset) begin
      vld_pipe <= '0;
      for (int k = 0; k <= STAGES; k++) tag_pipe[k] <= '0;
    end else begin
      vld_pipe    <= {vld_pipe[STAGES-1:0], accept};
      tag_pipe[0] <= '{dbz: sel_zero, id: gnt_id};
      for (int k = 1; k <= STAGES; k++) tag_pipe[k] <= tag_pipe[k-1];
    end
  end

  assign out_div_valid = vld_pipe[0];
  assign head_vld      = vld_pipe[STAGES];
  assign head_tag      = tag_pipe[STAGES];
  assign rsp_fire      = in_div_valid & head_vld;

  always_ff @(posedge in_clk) begin
    if (reset) begin
      out_rsp_valid     <= '0;
      out_rsp_quotient  <= '0;
      out_rsp_remainder <= '0;
      out_rsp_dbz       <= 1'b0;
      out_sync_error    <= 1'b0;
      drop_q            <= 1'b0;
    end else begin
      out_rsp_valid <= rsp_hit;
      drop_q        <= head_vld & ~in_div_valid;
      if (in_div_valid != head_vld) out_sync_error <= 1'b1;
      if (rsp_fire) begin
        out_rsp_dbz       <= head_tag.dbz;
        out_rsp_quotient  <= head_tag.dbz ? '1 : in_div_quotient;
        out_rsp_remainder <= head_tag.dbz ? '0 : in_div_remainder;
      end
    end
  end

  // A dropped op retires on the same cycle its response would have.
  assign rsp_dec = (|out_rsp_valid) | drop_q;

  always_ff @(posedge in_clk) begin
    if (reset)
      out_inflight <= '0;
    else if (accept && !rsp_dec)
      out_inflight <= out_inflight + CNT_W'(1);
    else if (!accept && rsp_dec)
      out_inflight <= out_inflight - CNT_W'(1);
  end
endmodule

// File: tb/tb_divider_arbiter.sv
// Randomized bench for divider_arbiter with a behavioural divider and a
// scoreboard reference model of arbitration, latency, dbz and sync errors.

module tb_divider_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int VW = 8;
  localparam int L  = 8;

  logic in_clk = 1'b0;
  logic reset  = 1'b1;
  always #5 in_clk = ~in_clk;

  logic [N-1:0]         in_req_valid = '0;
  logic [N-1:0]         out_req_ready;
  logic [N-1:0][DW-1:0] dvd = '0;
  logic [N-1:0][VW-1:0] dvs = '0;
  logic                 out_div_valid;
  logic [DW-1:0]        out_div_dividend;
  logic [VW-1:0]        out_div_divider;
  logic                 in_div_valid;
  logic [DW-1:0]        in_div_quotient;
  logic [VW-1:0]        in_div_remainder;
  logic [N-1:0]         out_rsp_valid;
  logic [DW-1:0]        out_rsp_quotient;
  logic [VW-1:0]        out_rsp_remainder;
  logic                 out_rsp_dbz;
  logic [$clog2(L+2):0] out_inflight;
  logic                 out_sync_error;
  logic                 inj  = 1'b0;
  logic                 kill = 1'b0;

  divider_arbiter #(.NUM_REQ(N), .DIVIDEND_WIDTH(DW), .DIVIDER_WIDTH(VW), .DIV_LATENCY(L)) dut (
    .in_clk            (in_clk),
    .reset             (reset),
    .in_req_valid      (in_req_valid),
    .out_req_ready     (out_req_ready),
    .in_req_dividend   (dvd),
    .in_req_divider    (dvs),
    .out_div_valid     (out_div_valid),
    .out_div_dividend  (out_div_dividend),
    .out_div_divider   (out_div_divider),
    .in_div_valid      (in_div_valid),
    .in_div_quotient   (in_div_quotient),
    .in_div_remainder  (in_div_remainder),
    .out_rsp_valid     (out_rsp_valid),
    .out_rsp_quotient  (out_rsp_quotient),
    .out_rsp_remainder (out_rsp_remainder),
    .out_rsp_dbz       (out_rsp_dbz),
    .out_inflight      (out_inflight),
    .out_sync_error    (out_sync_error)
  );

  // Behavioural pipelined divider, latency L, sharing the reset.
  logic [L:1]    dv_v;
  logic [DW-1:0] dq [1:L];
  logic [VW-1:0] dr [1:L];
  always @(posedge in_clk) begin
    if (reset) dv_v <= '0;
    else begin
      dv_v[1] <= out_div_valid;
      dq[1]   <= (out_div_divider != 0) ? out_div_dividend / out_div_divider : '1;
      dr[1]   <= (out_div_divider != 0) ? out_div_dividend % out_div_divider : '0;
      for (int k = 2; k <= L; k++) begin
        dv_v[k] <= dv_v[k-1];
        dq[k]   <= dq[k-1];
        dr[k]   <= dr[k-1];
      end
    end
  end
  assign in_div_valid     = (dv_v[L] & ~kill) | inj;
  assign in_div_quotient  = dq[L];
  assign in_div_remainder = dr[L];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  typedef struct {
    int            acc;
    int            id;
    logic [DW-1:0] q;
    logic [VW-1:0] r;
    logic          dbz;
    bit            drop;
  } op_t;

  op_t           sb[$];
  int            cyc = 0;
  int            p_exp = 0;
  int            maxv = 0;
  bit            sync_exp = 0;
  bit            rst_prev = 0;
  bit            iss_v = 0;
  logic [DW-1:0] iss_dvd;
  logic [VW-1:0] iss_dvs;
  logic [N-1:0]  er, erv;
  bit            found, hv, seen;
  int            gid, j;
  op_t           op;

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (reset) begin
      sb.delete();
      p_exp = 0; sync_exp = 0; iss_v = 0; rst_prev = 1;
    end else begin
      if (rst_prev) begin
        chk("rst_div_dividend", out_div_dividend, 0);
        chk("rst_div_divider", out_div_divider, 0);
        chk("rst_rsp_quotient", out_rsp_quotient, 0);
        chk("rst_rsp_remainder", out_rsp_remainder, 0);
        chk("rst_rsp_dbz", out_rsp_dbz, 0);
      end
      er = '0; found = 0; gid = 0;
      for (int k = 0; k < N; k++) begin
        j = (p_exp + k) % N;
        if (!found && in_req_valid[j]) begin er[j] = 1'b1; found = 1; gid = j; end
      end
      chk("ready", out_req_ready, er);
      chk("inflight", out_inflight, sb.size());
      if (int'(out_inflight) > maxv) maxv = int'(out_inflight);
      chk("div_valid", out_div_valid, iss_v);
      if (iss_v) begin
        chk("div_dividend", out_div_dividend, iss_dvd);
        chk("div_divider", out_div_divider, iss_dvs);
      end
      erv = '0;
      if (sb.size() > 0 && sb[0].acc + L + 2 == cyc) begin
        if (!sb[0].drop) begin
          erv[sb[0].id] = 1'b1;
          chk("rsp_quotient", out_rsp_quotient, sb[0].q);
          chk("rsp_remainder", out_rsp_remainder, sb[0].r);
          chk("rsp_dbz", out_rsp_dbz, sb[0].dbz);
        end
        void'(sb.pop_front());
      end
      chk("rsp_valid", out_rsp_valid, erv);
      chk("sync_error", out_sync_error, sync_exp);
      hv   = (sb.size() > 0) && (sb[0].acc + L + 1 == cyc);
      seen = (hv && !kill) || inj;
      if (seen != hv) sync_exp = 1;
      if (hv && !seen) sb[0].drop = 1;
      if (found) begin
        op.acc = cyc; op.id = gid; op.drop = 0;
        op.dbz = (dvs[gid] == 0);
        op.q   = op.dbz ? 8'hFF : dvd[gid] / dvs[gid];
        op.r   = op.dbz ? 8'h00 : dvd[gid] % dvs[gid];
        sb.push_back(op);
        iss_v = 1; iss_dvd = dvd[gid]; iss_dvs = op.dbz ? 8'd1 : dvs[gid];
        p_exp = (gid + 1) % N;
      end else begin
        iss_v = 0;
      end
      rst_prev = 0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge in_clk);
    #1;
  endtask

  task automatic rand_reqs(input int dens);
    for (int i = 0; i < N; i++) begin
      in_req_valid[i] = ($urandom_range(0, 99) < dens);
      dvd[i] = DW'($urandom);
      dvs[i] = ($urandom_range(0, 7) == 0) ? '0 : VW'($urandom);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; in_req_valid = '0;
    step(1);
    reset = 1'b0;
    step(1);
  endtask

  initial begin
    step(2);
    reset = 1'b0;
    step(1);

    // single op, 200/7
    in_req_valid = 4'b0001; dvd[0] = 8'd200; dvs[0] = 8'd7;
    step(1);
    in_req_valid = '0;
    step(12);

    // all requesters back-to-back from a fresh pointer
    do_reset();
    maxv = 0;
    for (int c = 0; c < 20; c++) begin
      rand_reqs(100);
      step(1);
    end
    in_req_valid = '0;
    chk("inflight_max", maxv, L + 2);
    step(12);

    // divide by zero from req2
    in_req_valid = 4'b0100; dvd[2] = 8'd55; dvs[2] = 8'd0;
    step(1);
    in_req_valid = '0;
    step(12);

    // move pointer to 2, then req1 and req3 contend
    in_req_valid = 4'b0010; dvd[1] = 8'd9; dvs[1] = 8'd2;
    step(1);
    in_req_valid = '0;
    step(1);
    in_req_valid = 4'b1010; dvd[3] = 8'd100; dvs[3] = 8'd10;
    step(3);
    in_req_valid = '0;
    step(14);

    // spurious divider valid on an empty tag line
    inj = 1'b1;
    step(1);
    inj = 1'b0;
    step(5);

    // missing divider valid: op dropped
    do_reset();
    in_req_valid = 4'b1000; dvd[3] = 8'd77; dvs[3] = 8'd3;
    step(1);
    in_req_valid = '0;
    step(L);
    kill = 1'b1;
    step(1);
    kill = 1'b0;
    step(6);

    // reset with traffic in flight
    do_reset();
    for (int c = 0; c < 5; c++) begin
      rand_reqs(100);
      step(1);
    end
    reset = 1'b1;
    step(1);
    reset = 1'b0; in_req_valid = '0;
    step(1);
    rand_reqs(100);
    step(1);

    for (int c = 0; c < 400; c++) begin
      rand_reqs($urandom_range(10, 90));
      step(1);
    end
    in_req_valid = '0;
    step(L + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one pipelined divider_top instance among NUM_REQ requesters.
- Round-robin arbitration, one operation issued per cycle.
- Each operation's requester ID is carried through a tag shift line matched to the divider latency, and the result is steered back to that requester.
- Handles divide-by-zero without feeding a zero divisor to the divider, and flags divider/tag misalignment.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DIVIDEND_WIDTH, 8, dividend/quotient width
DIVIDER_WIDTH, 8, divisor/remainder width
DIV_LATENCY, 8, cycles from divider in_data_valid to its out_data_valid (≥1)
TAG_W, $clog2(NUM_REQ), localparam, requester ID width

Ports:
in_clk  input  1  clock
reset  input  1  synchronous active-high reset
in_req_valid  input  NUM_REQ  per-requester request valid
out_req_ready  output  NUM_REQ  one-hot grant; request accepted when valid&ready
in_req_dividend  input  NUM_REQ*DIVIDEND_WIDTH  packed dividends, requester i at [i*DW +: DW]
in_req_divider  input  NUM_REQ*DIVIDER_WIDTH  packed divisors, same packing
out_div_valid  output  1  to divider in_data_valid
out_div_dividend  output  DIVIDEND_WIDTH  to divider in_dividend
out_div_divider  output  DIVIDER_WIDTH  to divider in_divider
in_div_valid  input  1  from divider out_data_valid
in_div_quotient  input  DIVIDEND_WIDTH  from divider out_quotient
in_div_remainder  input  DIVIDER_WIDTH  from divider out_remainder
out_rsp_valid  output  NUM_REQ  one-hot response strobe, one cycle, no backpressure
out_rsp_quotient  output  DIVIDEND_WIDTH  shared response quotient
out_rsp_remainder  output  DIVIDER_WIDTH  shared response remainder
out_rsp_dbz  output  1  response was a divide-by-zero
out_inflight  output  $clog2(DIV_LATENCY+2)+1  operations issued and not yet responded
out_sync_error  output  1  sticky: divider valid disagreed with tag line

Behaviour:
- Reset is synchronous on posedge in_clk, reset=1 and in_clk only. Next edge, all outputs are 0:
  - tag line valids cleared, rr pointer = 0, inflight = 0, out_sync_error = 0.
  - Reset mid-operation discards all outstanding ops; no responses are produced for them.
  - The divider shares this reset.
- Arbitration, combinational:
  - Search starts at rr pointer p, rising index with wrap.
  - First i with in_req_valid[i]=1 gets out_req_ready[i]=1; all other ready bits are 0.
  - out_req_ready may depend on in_req_valid; requesters must not make valid depend on ready.
  - No valid requester → ready all 0.
  - On accept, p ← grantee+1 mod NUM_REQ; otherwise p holds.
- Issue (registered, 1 cycle after accept):
  - out_div_valid=1 with the granted operands.
  - If the divisor is 0, out_div_divider is forced to 1 and tag dbz=1.
  - Idle cycle → out_div_valid=0; operands hold their last value.
- Tag line: DIV_LATENCY stages of {valid, id, dbz}, loaded in the cycle out_div_valid is registered, shifted every cycle.
- Return (registered, 1 cycle after in_div_valid):
  - out_rsp_valid[head.id]=1.
  - If dbz=0: quotient/remainder = divider outputs, out_rsp_dbz=0.
  - If dbz=1: quotient = all ones, remainder = 0, out_rsp_dbz=1.
- Total latency: accept at edge T → out_rsp_valid at T+DIV_LATENCY+2.
- Order and throughput: responses return in issue order; one per cycle sustained.
- Sync check: if in_div_valid ≠ tag head valid, then out_sync_error←1 (sticky until reset).
  - Spurious in_div_valid: response suppressed.
  - Missing in_div_valid: op dropped.
- out_inflight: +1 on accept, −1 on response; both in the same cycle → unchanged. Never exceeds DIV_LATENCY+2.

Test Plan:
1. Only req0: dividend 200, divisor 7, accepted at edge T → out_div_valid at T+1 with 200/7; out_rsp_valid=4'b0001 at T+10, quotient 28, remainder 4, dbz 0.
2. All four valid continuously from reset (p=0) → grants 0,1,2,3,0,… one per cycle; responses arrive one per cycle in the same order with correct quotients; out_inflight saturates at 10.
3. Req2: dividend 55, divisor 0 → out_div_divider=1; out_rsp_valid=4'b0100, quotient 255, remainder 0, dbz 1.
4. Req1 and req3 valid with p=2 → req3 granted first, then req1 (wrap), then req3 again.
5. Force in_div_valid=1 for one cycle with an empty tag line → out_sync_error=1 and stays 1; out_rsp_valid stays 0.
6. Assert reset with 5 operations in flight → next cycle all outputs 0, out_inflight 0; no out_rsp_valid afterwards; the first new request is granted from req0.
